// File: rtl/sine_dds_core.sv
// sine_dds_core: DDS front end for the sigma-delta DAC path.
//
// A phase accumulator advances by tuning_word on every sample_tick. The top
// QLUT_DEPTH phase bits (plus phase_offset) are folded onto a 64-entry
// quarter-wave table. The full-wave signed sine is rebuilt by mirroring the
// address in quadrants 1/3 and negating in quadrants 2/3. Samples are handed
// downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   sample_tick   one-cycle sample-rate strobe
//   tuning_word   phase increment per tick (sampled on tick)
//   phase_offset  added to the top phase bits before folding (sampled on tick)
//   amplitude     unsigned Q0.16 gain, only with SINE_DDS_AMPLITUDE_EN
//   out_sample    signed two's-complement sample
//   out_valid     out_sample holds an unconsumed sample
//   out_ready     consumer accepts when out_valid && out_ready
//   overrun       sticky: an unconsumed sample was overwritten
//
// Optional build macro: SINE_DDS_AMPLITUDE_EN (adds amplitude port and a
// scaling stage; latency 3 -> 4 edges).

// Quarter-wave table: floor(32767 * sin(2*pi*(i + 0.5) / 256)), i = 0..63.
// The half-sample offset keeps zero and duplicate points off the quadrant
// edges and caps the peak at 0x7FFC. Registered read (one cycle latency).
module sine_qlut #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  function automatic logic [15:0] qsin(input logic [5:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      6'd0:  r = 16'd402;   6'd1:  r = 16'd1206;  6'd2:  r = 16'd2009;  6'd3:  r = 16'd2811;
      6'd4:  r = 16'd3611;  6'd5:  r = 16'd4409;  6'd6:  r = 16'd5205;  6'd7:  r = 16'd5997;
      6'd8:  r = 16'd6786;  6'd9:  r = 16'd7571;  6'd10: r = 16'd8351;  6'd11: r = 16'd9126;
      6'd12: r = 16'd9895;  6'd13: r = 16'd10659; 6'd14: r = 16'd11416; 6'd15: r = 16'd12166;
      6'd16: r = 16'd12909; 6'd17: r = 16'd13645; 6'd18: r = 16'd14372; 6'd19: r = 16'd15090;
      6'd20: r = 16'd15799; 6'd21: r = 16'd16499; 6'd22: r = 16'd17189; 6'd23: r = 16'd17868;
      6'd24: r = 16'd18537; 6'd25: r = 16'd19194; 6'd26: r = 16'd19840; 6'd27: r = 16'd20474;
      6'd28: r = 16'd21096; 6'd29: r = 16'd21705; 6'd30: r = 16'd22301; 6'd31: r = 16'd22883;
      6'd32: r = 16'd23452; 6'd33: r = 16'd24006; 6'd34: r = 16'd24546; 6'd35: r = 16'd25072;
      6'd36: r = 16'd25582; 6'd37: r = 16'd26077; 6'd38: r = 16'd26556; 6'd39: r = 16'd27019;
      6'd40: r = 16'd27466; 6'd41: r = 16'd27896; 6'd42: r = 16'd28309; 6'd43: r = 16'd28706;
      6'd44: r = 16'd29085; 6'd45: r = 16'd29446; 6'd46: r = 16'd29790; 6'd47: r = 16'd30116;
      6'd48: r = 16'd30424; 6'd49: r = 16'd30713; 6'd50: r = 16'd30984; 6'd51: r = 16'd31236;
      6'd52: r = 16'd31470; 6'd53: r = 16'd31684; 6'd54: r = 16'd31880; 6'd55: r = 16'd32056;
      6'd56: r = 16'd32213; 6'd57: r = 16'd32350; 6'd58: r = 16'd32468; 6'd59: r = 16'd32567;
      6'd60: r = 16'd32646; 6'd61: r = 16'd32705; 6'd62: r = 16'd32744; 6'd63: r = 16'd32764;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    data <= DATA_WIDTH'(qsin(6'(addr)));
  end
endmodule

module sine_dds_core #(
  parameter int PHASE_WIDTH = 32,
  parameter int QLUT_DEPTH  = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic [PHASE_WIDTH-1:0] tuning_word,
  input  logic [QLUT_DEPTH-1:0]  phase_offset,
`ifdef SINE_DDS_AMPLITUDE_EN
  input  logic [DATA_WIDTH-1:0]  amplitude,
`endif
  output logic [DATA_WIDTH-1:0]  out_sample,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun
);
  localparam int AW = QLUT_DEPTH - 2;

  logic [PHASE_WIDTH-1:0] acc;
  logic [QLUT_DEPTH-1:0]  p;
  logic                   v1, v2, v3;
  logic [1:0]             q;
  logic [AW-1:0]          idx;
  logic [AW-1:0]          addr;
  logic                   neg2, neg3;
  logic [DATA_WIDTH-1:0]  lut;
  logic [DATA_WIDTH-1:0]  full;
  logic                   new_valid;
  logic [DATA_WIDTH-1:0]  new_data;

  // Stage 0: fold point from the pre-increment accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= sample_tick;
      if (sample_tick) begin
        p   <= acc[PHASE_WIDTH-1 -: QLUT_DEPTH] + phase_offset;
        acc <= acc + tuning_word;
      end
    end
  end

  assign q   = p[QLUT_DEPTH-1 -: 2];
  assign idx = p[AW-1:0];

  // Stage 1: mirror the index on odd quadrants, remember the sign.
  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
    if (v1) begin
      addr <= q[0] ? ~idx : idx;
      neg2 <= q[1];
    end
  end

  sine_qlut #(.ADDR_WIDTH(AW), .DATA_WIDTH(DATA_WIDTH)) u_qlut (
    .clk  (clk),
    .addr (addr),
    .data (lut)
  );

  // Table read cycle: sign and valid travel alongside the registered ROM.
  always_ff @(posedge clk) begin
    if (rst) v3 <= 1'b0;
    else     v3 <= v2;
    neg3 <= neg2;
  end

  assign full = neg3 ? -lut : lut;

`ifdef SINE_DDS_AMPLITUDE_EN
  logic [DATA_WIDTH-1:0]         amp1, amp2, amp3, amp4;
  logic                          v4;
  logic [DATA_WIDTH-1:0]         s4;
  logic signed [2*DATA_WIDTH:0]  prod;

  always_ff @(posedge clk) begin
    if (sample_tick) amp1 <= amplitude;
    amp2 <= amp1;
    amp3 <= amp2;
    if (rst) v4 <= 1'b0;
    else     v4 <= v3;
    if (v3) begin
      s4   <= full;
      amp4 <= amp3;
    end
  end

  assign prod      = $signed(s4) * $signed({1'b0, amp4});
  assign new_valid = v4;
  assign new_data  = prod[2*DATA_WIDTH-1 -: DATA_WIDTH];
`else
  assign new_valid = v3;
  assign new_data  = full;
`endif

  // Output register and handshake: a new sample always loads; overwriting an
  // unaccepted one raises the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (new_valid) begin
      out_sample <= new_data;
      out_valid  <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sine_dds_core.sv
module tb_sine_dds_core;
  localparam int PW = 32;
  localparam int QD = 8;
  localparam int DW = 16;
`ifdef SINE_DDS_AMPLITUDE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic [PW-1:0] tuning_word = '0;
  logic [QD-1:0] phase_offset = '0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          overrun;
`ifdef SINE_DDS_AMPLITUDE_EN
  logic [DW-1:0] amplitude = 16'hFFFF;
`endif

  always #5 clk = ~clk;

  sine_dds_core #(.PHASE_WIDTH(PW), .QLUT_DEPTH(QD), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .tuning_word  (tuning_word),
    .phase_offset (phase_offset),
`ifdef SINE_DDS_AMPLITUDE_EN
    .amplitude    (amplitude),
`endif
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Ideal sine sample for full-wave point ph (0..255), half-point offset,
  // scaled by 32767 and truncated toward zero.
  function automatic int sine_ref(input int unsigned ph);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(ph) + 0.5) / 256.0);
    return $rtoi(v);
  endfunction

  function automatic logic [15:0] to16(input int v);
    return v[15:0];
  endfunction

  // Reference model: each tick schedules a sample LAT edges later; the
  // output register follows the valid/ready/overrun rules.
  logic [PW-1:0] m_acc = '0;
  int unsigned   cyc = 0;
  int unsigned   arr_cyc[$];
  logic [DW-1:0] arr_val[$];
  logic          m_valid = 1'b0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] m_sample = '0;

  always @(posedge clk) begin
    int unsigned ph;
    longint      s;
    cyc++;
    if (rst) begin
      arr_cyc.delete();
      arr_val.delete();
      m_acc    = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_sample = '0;
    end else begin
      if (arr_cyc.size() > 0 && arr_cyc[0] == cyc) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        m_sample = arr_val.pop_front();
        void'(arr_cyc.pop_front());
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (sample_tick) begin
        ph = ((int'(m_acc >> (PW - QD))) + int'(phase_offset)) % 256;
        s  = longint'(sine_ref(ph));
`ifdef SINE_DDS_AMPLITUDE_EN
        s = (s * longint'(amplitude)) >>> 16;
`endif
        arr_cyc.push_back(cyc + LAT);
        arr_val.push_back(s[DW-1:0]);
        m_acc = m_acc + tuning_word;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
    chk("cyc_sample", 32'(out_sample), 32'(m_sample));
  end

  // Accepted-sample logs.
  int            log_sel = 0;
  logic [DW-1:0] log1[$];
  logic [DW-1:0] log2[$];

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (log_sel == 1) log1.push_back(out_sample);
      if (log_sel == 2) log2.push_back(out_sample);
    end
  end

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      @(negedge clk);
    end
    sample_tick = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Reset held for three edges while ticks toggle.
    rst = 1'b1; sample_tick = 1'b1; out_ready = 1'b1;
    tuning_word = 32'h0100_0000; phase_offset = '0;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    chk("rst_sample", 32'(out_sample), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // Pin the model to hand-computed points.
    chk("model_p0", 32'(to16(sine_ref(0))), 32'h0192);
    chk("model_p1", 32'(to16(sine_ref(1))), 32'h04B6);
    chk("model_p64", 32'(to16(sine_ref(64))), 32'h7FFC);
    chk("model_p128", 32'(to16(sine_ref(128))), 32'hFE6E);
    chk("model_p192", 32'(to16(sine_ref(192))), 32'h8004);

    // First tick after release: latency measurement.
    rst = 1'b0; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
`ifndef SINE_DDS_AMPLITUDE_EN
    chk("first_sample", 32'(out_sample), 32'h0192);
`endif
    drain();

    // Full period at one phase step per tick.
    pulse_rst();
    tuning_word = 32'h0100_0000; phase_offset = '0; out_ready = 1'b1;
    log1.delete(); log_sel = 1;
    run_ticks(264);
    drain();
    log_sel = 0;
    chk("t2_count", 32'(log1.size()), 32'd264);
`ifndef SINE_DDS_AMPLITUDE_EN
    chk("t2_s0", 32'(log1[0]), 32'h0192);
    chk("t2_s1", 32'(log1[1]), 32'h04B6);
    chk("t2_s2", 32'(log1[2]), 32'h07D9);
    chk("t2_s64", 32'(log1[64]), 32'h7FFC);
    chk("t2_s127", 32'(log1[127]), 32'h0192);
    chk("t2_s128", 32'(log1[128]), 32'hFE6E);
    chk("t2_s192", 32'(log1[192]), 32'h8004);
`endif
    for (int k = 0; k < 8; k++) chk("t2_period", 32'(log1[k + 256]), 32'(log1[k]));

    // Quarter-period phase offset gives the cosine.
    pulse_rst();
    phase_offset = 8'h40;
    log2.delete(); log_sel = 2;
    run_ticks(256);
    drain();
    log_sel = 0;
    chk("t3_count", 32'(log2.size()), 32'd256);
`ifndef SINE_DDS_AMPLITUDE_EN
    chk("t3_s0", 32'(log2[0]), 32'h7FFC);
`endif
    for (int k = 0; k < 256; k++) chk("t3_rotate", 32'(log2[k]), 32'(log1[(k + 64) % 256]));

    // Half-rate tuning word: accumulator wraps every second tick.
    pulse_rst();
    phase_offset = '0; tuning_word = 32'h8000_0000;
    log1.delete(); log_sel = 1;
    run_ticks(8);
    drain();
    log_sel = 0;
    chk("t4_count", 32'(log1.size()), 32'd8);
`ifndef SINE_DDS_AMPLITUDE_EN
    for (int k = 0; k < 8; k++)
      chk("t4_alt", 32'(log1[k]), (k % 2 == 1) ? 32'h0000FE6E : 32'h00000192);
`endif

    // Backpressure: five samples with the consumer stalled.
    pulse_rst();
    tuning_word = 32'h0100_0000; out_ready = 1'b0;
    run_ticks(5);
    drain();
    chk("t5_overrun", 32'(overrun), 32'h1);
    chk("t5_valid", 32'(out_valid), 32'h1);
`ifndef SINE_DDS_AMPLITUDE_EN
    chk("t5_latest", 32'(out_sample), 32'h0E1B);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept_valid", 32'(out_valid), 32'h0);
    chk("t5_sticky", 32'(overrun), 32'h1);
    @(negedge clk);
    chk("t5_no_stale", 32'(out_valid), 32'h0);

    // Accept and new arrival on the same edge: no overrun.
    pulse_rst();
    out_ready = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wait", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'h1);
    chk("t6_overrun", 32'(overrun), 32'h0);
`ifndef SINE_DDS_AMPLITUDE_EN
    chk("t6_sample", 32'(out_sample), 32'h04B6);
`endif
    @(negedge clk);
    chk("t6_drained", 32'(out_valid), 32'h0);

`ifdef SINE_DDS_AMPLITUDE_EN
    // Half amplitude.
    pulse_rst();
    amplitude = 16'h8000; tuning_word = 32'h0100_0000;
    log1.delete(); log_sel = 1;
    run_ticks(65);
    drain();
    log_sel = 0;
    chk("amp_half_s0", 32'(log1[0]), 32'h00C9);
    chk("amp_half_s64", 32'(log1[64]), 32'h3FFE);
    // Zero amplitude.
    pulse_rst();
    amplitude = 16'h0000;
    log1.delete(); log_sel = 1;
    run_ticks(16);
    drain();
    log_sel = 0;
    chk("amp_zero_count", 32'(log1.size()), 32'd16);
    for (int k = 0; k < 16; k++) chk("amp_zero", 32'(log1[k]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
